sram_bist_sequencer: RTL and testbench
======================================

// Module: sram_bist_sequencer
// PURPOSE
//  Sequences the external address-counter chip and the two 4-bit SRAM chips (CHIP1 = DATA[3:0], CHIP2 = DATA[7:4]).
//  Fill pass: writes an 8-bit LFSR pattern seeded from SEED to every address.
//  Verify pass: reads every address back, compares, and reports pass/fail and error statistics.
//  Sits between TOP-level pads (tristate buffers live in TOP) and status/LED logic.
// PARAMETERS
//  ADDR_BITS  8  external counter width; 2**ADDR_BITS locations tested
//  CLK_DIV    4  CLK cycles per COUNTER_RST pulse, per WE_BAR low pulse, and per COUNTER_CLK high/low half
//  SETTLE     2  CLK cycles data is held before and after WE_BAR low; extra read settle time
// PORTS
//  CLK             in   1          system clock
//  RST_N           in   1          asynchronous, active-low reset
//  START           in   1          begin test; sampled only in IDLE or DONE
//  SEED            in   8          LFSR seed, latched when START is accepted
//  COUNTER_CLK     out  1          external address counter clock; counter advances on its rising edge
//  COUNTER_RST     out  1          external counter reset, active-high
//  WE_BAR          out  1          SRAM write enable, active-low
//  DATA_OUT        out  8          write data to pads
//  DATA_OE         out  1          1 = TOP drives DATA_OUT onto the pads
//  DATA_IN         in   8          read data from pads
//  BUSY            out  1          test in progress
//  DONE            out  1          test complete; held until next START
//  PASS            out  1          valid when DONE: 1 = ERR_COUNT == 0
//  ERR_COUNT       out  ADDR_BITS+1  mismatching addresses (cannot overflow)
//  FIRST_ERR_ADDR  out  ADDR_BITS  address of the first mismatch; 0 if none
// BEHAVIOUR
//  Reset (async, immediate):
//   - COUNTER_RST=1; WE_BAR=1; DATA_OE=0.
//   - All other outputs 0; state IDLE.
//  LFSR: next = {l[6:0], l[7]^l[5]^l[4]^l[3]}. Load value is SEED, or 8'h01 if SEED==0.
//  Shadow address counter addr (ADDR_BITS) mirrors the external counter.
//   - Cleared with every COUNTER_RST pulse.
//   - +1 (wrapping) on every COUNTER_CLK rising edge.
//  FSM; each state occupies the stated number of CLK cycles:
//   - IDLE: COUNTER_RST=1. On START: latch SEED, clear ERR_COUNT/FIRST_ERR_ADDR/DONE/PASS, BUSY=1, go W_RST.
//   - W_RST (CLK_DIV): COUNTER_RST=1; addr=0; LFSR loaded.
//   - W_SETUP (SETTLE): DATA_OE=1, DATA_OUT=LFSR, WE_BAR=1.
//   - W_PULSE (CLK_DIV): WE_BAR=0; DATA_OUT stable.
//   - W_HOLD (SETTLE): WE_BAR=1; data still driven.
//   - W_ADV_HI (CLK_DIV), then W_ADV_LO (CLK_DIV): COUNTER_CLK=1 then 0; addr+1; LFSR steps at W_ADV_LO entry.
//     Exit: if pre-increment addr was all-ones, go R_RST (counter has wrapped to 0); else go W_SETUP.
//   - R_RST (CLK_DIV): DATA_OE=0; COUNTER_RST=1; addr=0; LFSR reloaded.
//   - R_WAIT (SETTLE+CLK_DIV): DATA_IN sampled on the last cycle and compared with LFSR.
//     On mismatch: ERR_COUNT+1; if first error, capture FIRST_ERR_ADDR=addr.
//   - R_ADV_HI/R_ADV_LO: as in the write pass. Exit: after last address go DONE, else R_WAIT.
//   - DONE: BUSY=0, DONE=1, PASS=(ERR_COUNT==0), COUNTER_RST=1. START restarts as in IDLE.
//  Invariants:
//   - WE_BAR=0 only in W_PULSE, hence only while DATA_OE=1.
//   - DATA_OUT never changes while WE_BAR=0.
//   - DATA_OE=0 in every read state.
//   - COUNTER_CLK and COUNTER_RST never both 1.
//  START while BUSY is ignored (level-held START does not retrigger until DONE).
//  Latency, defaults (write 16 cycles/addr, read 14, 2 resets of 4): DONE rises 7688 CLK edges after the START-sampling edge.
//  RST_N low mid-operation: WE_BAR=1 and DATA_OE=0 asynchronously; no partial write completes afterwards.
// TESTING
//  1. Hold RST_N=0 -> COUNTER_RST=1, WE_BAR=1, DATA_OE=0, BUSY=DONE=PASS=0, ERR_COUNT=0.
//  2. Ideal SRAM model, SEED=23, START pulse:
//     - Address 0 written 8'h17, address 1 written 8'h2F.
//     - DONE after 7688 cycles; PASS=1, ERR_COUNT=0.
//  3. Model returns inverted data at address 5 -> ERR_COUNT=1, FIRST_ERR_ADDR=5, PASS=0.
//  4. SEED=0 -> address 0 written 8'h01, address 1 written 8'h02; PASS=1.
//  5. RST_N dropped during W_PULSE:
//     - WE_BAR=1 and DATA_OE=0 before the next CLK edge.
//     - After release and START: clean full run, PASS=1.
//  6. START held high throughout: no retrigger while BUSY. New START in DONE clears ERR_COUNT and reruns.
//     Always-on protocol checker: WE_BAR falls only after DATA_OE=1 and stable DATA_OUT for >= SETTLE cycles.

Source files
------------

// File: rtl/sram_bist_sequencer_if.sv
// sram_bist_sequencer_if: pad, control and status signals between the BIST sequencer and TOP
interface sram_bist_sequencer_if #(parameter int ADDR_BITS = 8);
   logic                 start;
   logic [7:0]           seed;
   logic                 counter_clk;
   logic                 counter_rst;
   logic                 we_bar;
   logic [7:0]           data_out;
   logic                 data_oe;
   logic [7:0]           data_in;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [ADDR_BITS:0]   err_count;
   logic [ADDR_BITS-1:0] first_err_addr;
   modport master (
      input  start, seed, data_in,
      output counter_clk, counter_rst, we_bar, data_out, data_oe, busy, done, pass, err_count, first_err_addr
   );
   modport slave (
      output start, seed, data_in,
      input  counter_clk, counter_rst, we_bar, data_out, data_oe, busy, done, pass, err_count, first_err_addr
   );
endinterface

// File: rtl/sram_bist_sequencer.sv
// sram_bist_sequencer: LFSR fill/verify BIST for two 4-bit SRAMs behind an external address counter
module sram_bist_sequencer #(
   parameter int ADDR_BITS = 8,
   parameter int CLK_DIV   = 4,
   parameter int SETTLE    = 2
) (
   input logic                   clk,
   input logic                   rst_n,
   sram_bist_sequencer_if.master bus
);
   localparam logic [3:0] IDLE = 4'd0, W_RST = 4'd1, W_SETUP = 4'd2, W_PULSE = 4'd3, W_HOLD = 4'd4,
                          W_ADV_HI = 4'd5, W_ADV_LO = 4'd6, R_RST = 4'd7, R_WAIT = 4'd8,
                          R_ADV_HI = 4'd9, R_ADV_LO = 4'd10, DONE = 4'd11;
   localparam logic [7:0] T_DIV = 8'(CLK_DIV), T_SET = 8'(SETTLE), T_WAIT = 8'(SETTLE + CLK_DIV);
   logic [3:0]           state_q, state_d;
   logic [7:0]           cnt_q, cnt_d, seed_q, seed_d, lfsr_q, lfsr_d, lfsr_load, lfsr_next, dur;
   logic [ADDR_BITS-1:0] addr_q, addr_d, first_q, first_d;
   logic [ADDR_BITS:0]   err_q, err_d;
   logic                 fin, idle, oe;
   always_comb begin
      idle      = state_q == IDLE || state_q == DONE;
      dur       = (state_q == W_SETUP || state_q == W_HOLD) ? T_SET : state_q == R_WAIT ? T_WAIT : T_DIV;
      fin       = cnt_q == dur - 8'd1;
      lfsr_load = seed_q == 8'd0 ? 8'h01 : seed_q;
      lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      state_d   = state_q;
      cnt_d     = (idle || fin) ? 8'd0 : cnt_q + 8'd1;
      seed_d    = seed_q;
      lfsr_d    = lfsr_q;
      addr_d    = addr_q;
      first_d   = first_q;
      err_d     = err_q;
      case (state_q)
         IDLE, DONE: if (bus.start) begin
            state_d = W_RST;
            seed_d  = bus.seed;
            err_d   = '0;
            first_d = '0;
         end
         W_RST, R_RST: begin
            addr_d = '0;
            lfsr_d = lfsr_load;
            if (fin) state_d = state_q == W_RST ? W_SETUP : R_WAIT;
         end
         W_SETUP: if (fin) state_d = W_PULSE;
         W_PULSE: if (fin) state_d = W_HOLD;
         W_HOLD, R_WAIT: if (fin) begin
            state_d = state_q == W_HOLD ? W_ADV_HI : R_ADV_HI;
            addr_d  = addr_q + 1'b1;
            if (state_q == R_WAIT && bus.data_in != lfsr_q) begin
               err_d = err_q + 1'b1;
               if (err_q == '0) first_d = addr_q;
            end
         end
         W_ADV_HI, R_ADV_HI: if (fin) begin
            state_d = state_q == W_ADV_HI ? W_ADV_LO : R_ADV_LO;
            lfsr_d  = lfsr_next;
         end
         W_ADV_LO: if (fin) state_d = addr_q == '0 ? R_RST : W_SETUP;
         R_ADV_LO: if (fin) state_d = addr_q == '0 ? DONE : R_WAIT;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         seed_q  <= '0;
         lfsr_q  <= '0;
         addr_q  <= '0;
         first_q <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         seed_q  <= seed_d;
         lfsr_q  <= lfsr_d;
         addr_q  <= addr_d;
         first_q <= first_d;
         err_q   <= err_d;
      end
   assign oe                 = state_q == W_SETUP || state_q == W_PULSE || state_q == W_HOLD;
   assign bus.data_oe        = oe;
   assign bus.data_out       = oe ? lfsr_q : 8'd0;
   assign bus.we_bar         = state_q != W_PULSE;
   assign bus.counter_clk    = state_q == W_ADV_HI || state_q == R_ADV_HI;
   assign bus.counter_rst    = idle || state_q == W_RST || state_q == R_RST;
   assign bus.busy           = !idle;
   assign bus.done           = state_q == DONE;
   assign bus.pass           = state_q == DONE && err_q == '0;
   assign bus.err_count      = err_q;
   assign bus.first_err_addr = first_q;
endmodule

// File: tb/tb_sram_bist_sequencer.sv
// tb_sram_bist_sequencer: randomized bench with SRAM/counter model, LFSR reference and protocol monitor
module tb_sram_bist_sequencer;
   localparam int N = 256, LAT = 7688, SETTLE = 2, CLK_DIV = 4;
   logic       clk = 1'b0, rst_n = 1'b0;
   int         total = 0, passed = 0, run_id = 0;
   int         proto_bad = 0, oe_cyc = 0, we_cyc = 0, wr_cnt = 0, stab = 0;
   logic [7:0] mem [N];
   int         wgen [N];
   bit         flt [N];
   logic [7:0] ext = 8'd0, wdat = 8'd0, waddr = 8'd0, prev_do = 8'd0;
   logic       cc_prev = 1'b0, prev_we = 1'b1, prev_oe = 1'b0;

   sram_bist_sequencer_if bus();
   sram_bist_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;
   assign bus.data_in = flt[ext] ? ~mem[ext] : mem[ext];

   always @(posedge clk) begin
      if (bus.counter_rst) ext <= 8'd0;
      else if (bus.counter_clk && !cc_prev) ext <= ext + 8'd1;
      cc_prev <= bus.counter_clk;
   end

   always @(negedge bus.we_bar) begin
      wdat  = bus.data_out;
      waddr = ext;
   end

   always @(posedge bus.we_bar)
      if (rst_n && bus.data_oe) begin
         mem[waddr]  = wdat;
         wgen[waddr] = run_id;
         wr_cnt++;
      end

   always @(negedge clk) begin
      if (!rst_n) begin
         stab = 0;
         prev_we = 1'b1;
         prev_oe = 1'b0;
      end else begin
         if (bus.counter_clk && bus.counter_rst) begin
            proto_bad++;
            $display("FAIL proto clk_rst: counter_clk=%b counter_rst=%b required not both 1 at %0t", bus.counter_clk, bus.counter_rst, $time);
         end
         if (!bus.we_bar && prev_we && stab < SETTLE) begin
            proto_bad++;
            $display("FAIL proto setup: stable cycles %0d required >= %0d at %0t", stab, SETTLE, $time);
         end
         if (!bus.we_bar && (!bus.data_oe || (!prev_we && bus.data_out !== prev_do))) begin
            proto_bad++;
            $display("FAIL proto pulse: oe=%b data_out=%h prev=%h required oe=1 and stable at %0t", bus.data_oe, bus.data_out, prev_do, $time);
         end
         stab = bus.data_oe ? ((prev_oe && bus.data_out === prev_do) ? stab + 1 : 1) : 0;
         if (bus.data_oe) oe_cyc++;
         if (!bus.we_bar) we_cyc++;
         prev_we = bus.we_bar;
         prev_do = bus.data_out;
         prev_oe = bus.data_oe;
      end
   end

   function automatic logic [7:0] pat(input logic [7:0] sd, input int i);
      logic [7:0] l;
      l = (sd == 8'd0) ? 8'h01 : sd;
      for (int k = 0; k < i; k++) l = {l[6:0], ^(l & 8'hB8)};
      return l;
   endfunction

   function automatic int mem_bad(input logic [7:0] sd);
      int b = 0;
      for (int i = 0; i < N; i++) if (wgen[i] != run_id || mem[i] !== pat(sd, i)) b++;
      return b;
   endfunction

   task automatic exp_errs(output int e, output int f);
      e = 0;
      f = 0;
      for (int i = N - 1; i >= 0; i--) if (flt[i]) begin
         e++;
         f = i;
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (bus.done !== 1'b1 && n < LAT + 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (bus.done !== 1'b1) n = -1;
   endtask

   task automatic go(input logic [7:0] sd, input bit hold, output int n);
      run_id++;
      @(negedge clk);
      bus.seed  = sd;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) bus.start = 1'b0;
      wait_done(n);
   endtask

   task automatic test_reset();
      bus.start = 1'b0;
      bus.seed  = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({bus.counter_rst, bus.we_bar, bus.data_oe, bus.busy, bus.done, bus.pass, bus.counter_clk} !== 7'b1100000)
         $display("FAIL reset ctrl: rst,we_bar,oe,busy,done,pass,cclk=%b expected 1100000", {bus.counter_rst, bus.we_bar, bus.data_oe, bus.busy, bus.done, bus.pass, bus.counter_clk});
      else passed++;
      total++;
      if (bus.err_count !== 9'd0 || bus.first_err_addr !== 8'd0 || bus.data_out !== 8'd0)
         $display("FAIL reset stats: err=%0d first=%0d dout=%h expected 0 0 00", bus.err_count, bus.first_err_addr, bus.data_out);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_fill_verify();
      int n, oe0, we0;
      oe0 = oe_cyc;
      we0 = we_cyc;
      go(8'd23, 1'b0, n);
      total++;
      if (n != LAT) $display("FAIL fill latency: got %0d expected %0d", n, LAT); else passed++;
      total++;
      if ({bus.busy, bus.done, bus.pass} !== 3'b011 || bus.err_count !== 9'd0)
         $display("FAIL fill status: busy,done,pass=%b err=%0d expected 011 0", {bus.busy, bus.done, bus.pass}, bus.err_count);
      else passed++;
      total++;
      if (mem[0] !== 8'h17 || mem[1] !== 8'h2F) $display("FAIL fill first: mem0=%h mem1=%h expected 17 2f", mem[0], mem[1]); else passed++;
      total++;
      if (mem_bad(8'd23) != 0) $display("FAIL fill pattern: %0d bad addresses expected 0", mem_bad(8'd23)); else passed++;
      total++;
      if (oe_cyc - oe0 != N * (2 * SETTLE + CLK_DIV) || we_cyc - we0 != N * CLK_DIV)
         $display("FAIL fill cycles: oe=%0d we=%0d expected %0d %0d", oe_cyc - oe0, we_cyc - we0, N * (2 * SETTLE + CLK_DIV), N * CLK_DIV);
      else passed++;
   endtask

   task automatic test_fault();
      int n;
      flt[5] = 1'b1;
      go(8'd23, 1'b0, n);
      flt[5] = 1'b0;
      total++;
      if (n != LAT) $display("FAIL fault latency: got %0d expected %0d", n, LAT); else passed++;
      total++;
      if (bus.err_count !== 9'd1 || bus.first_err_addr !== 8'd5 || bus.pass !== 1'b0)
         $display("FAIL fault stats: err=%0d first=%0d pass=%b expected 1 5 0", bus.err_count, bus.first_err_addr, bus.pass);
      else passed++;
   endtask

   task automatic test_seed_zero();
      int n;
      go(8'd0, 1'b0, n);
      total++;
      if (mem[0] !== 8'h01 || mem[1] !== 8'h02) $display("FAIL seed0 first: mem0=%h mem1=%h expected 01 02", mem[0], mem[1]); else passed++;
      total++;
      if (n != LAT || bus.pass !== 1'b1 || mem_bad(8'd0) != 0)
         $display("FAIL seed0 run: n=%0d pass=%b bad=%0d expected %0d 1 0", n, bus.pass, mem_bad(8'd0), LAT);
      else passed++;
   endtask

   task automatic test_reset_mid();
      int n, w0, k;
      logic [7:0] sd;
      sd = 8'($urandom);
      run_id++;
      @(negedge clk);
      bus.seed  = sd;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      k = 0;
      while (bus.we_bar !== 1'b0 && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      total++;
      if (bus.we_bar !== 1'b0) $display("FAIL midrst pulse: we_bar=%b expected 0 within 100 cycles", bus.we_bar); else passed++;
      @(posedge clk);
      #1;
      w0 = wr_cnt;
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.we_bar !== 1'b1 || bus.data_oe !== 1'b0 || bus.busy !== 1'b0)
         $display("FAIL midrst async: we_bar=%b oe=%b busy=%b expected 1 0 0", bus.we_bar, bus.data_oe, bus.busy);
      else passed++;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      total++;
      if (wr_cnt != w0 || bus.busy !== 1'b0) $display("FAIL midrst nowrite: writes=%0d busy=%b expected %0d 0", wr_cnt, bus.busy, w0); else passed++;
      go(sd, 1'b0, n);
      total++;
      if (n != LAT || bus.pass !== 1'b1 || mem_bad(sd) != 0)
         $display("FAIL midrst rerun: n=%0d pass=%b bad=%0d expected %0d 1 0", n, bus.pass, mem_bad(sd), LAT);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int n, e, f;
      logic [7:0] sd;
      sd = 8'($urandom);
      flt[$urandom_range(0, N - 1)] = 1'b1;
      flt[$urandom_range(0, N - 1)] = 1'b1;
      exp_errs(e, f);
      go(sd, 1'b1, n);
      total++;
      if (n != LAT) $display("FAIL b2b latency: got %0d expected %0d", n, LAT); else passed++;
      total++;
      if (bus.err_count !== 9'(e) || bus.first_err_addr !== 8'(f) || bus.pass !== 1'b0)
         $display("FAIL b2b stats: err=%0d first=%0d pass=%b expected %0d %0d 0", bus.err_count, bus.first_err_addr, bus.pass, e, f);
      else passed++;
      for (int i = 0; i < N; i++) flt[i] = 1'b0;
      run_id++;
      @(posedge clk);
      #1;
      total++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.err_count !== 9'd0)
         $display("FAIL b2b restart: busy=%b done=%b err=%0d expected 1 0 0", bus.busy, bus.done, bus.err_count);
      else passed++;
      bus.start = 1'b0;
      wait_done(n);
      total++;
      if (n != LAT || bus.pass !== 1'b1 || mem_bad(sd) != 0)
         $display("FAIL b2b rerun: n=%0d pass=%b bad=%0d expected %0d 1 0", n, bus.pass, mem_bad(sd), LAT);
      else passed++;
   endtask

   task automatic test_random();
      int n, e, f;
      logic [7:0] sd;
      sd = 8'($urandom);
      repeat ($urandom_range(1, 4)) flt[$urandom_range(0, N - 1)] = 1'b1;
      exp_errs(e, f);
      go(sd, 1'b0, n);
      for (int i = 0; i < N; i++) flt[i] = 1'b0;
      total++;
      if (n != LAT || bus.err_count !== 9'(e) || bus.first_err_addr !== 8'(f) || bus.pass !== (e == 0))
         $display("FAIL random stats: n=%0d err=%0d first=%0d pass=%b expected %0d %0d %0d %b", n, bus.err_count, bus.first_err_addr, bus.pass, LAT, e, f, e == 0);
      else passed++;
      total++;
      if (mem_bad(sd) != 0) $display("FAIL random pattern: %0d bad addresses expected 0 (seed %h)", mem_bad(sd), sd); else passed++;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         flt[i]  = 1'b0;
         wgen[i] = 0;
      end
      test_reset();
      test_fill_verify();
      test_fault();
      test_seed_zero();
      test_reset_mid();
      test_back_to_back();
      test_random();
      total++;
      if (proto_bad != 0) $display("FAIL protocol: %0d violations expected 0", proto_bad); else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
